rs_age_station: RTL and testbench

Parametrised reservation station for one functional unit: holds up to DEPTH renamed instructions and snoops NUM_CDB broadcast buses for missing operands. It issues the oldest ready entry through a valid/ready handshake and frees a slot only when its own result tag is broadcast. It sits between the dispatch unit and one adder or multiplier functional unit, and adds flush, multi-bus snooping and dispatch-time bypass.

---
 rtl/rs_pkg.sv | 26 ++
 rtl/rs_oldest_select.sv | 45 ++++
 rtl/rs_age_station.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rs_age_station.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the age-ordered reservation station.
//   rs_state_e  : per-entry lifecycle state
//   RS_DEF_*    : default parameter values
//   rs_make_tag : builds a result tag {unit_id, entry index}
package rs_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WAITING = 2'd1,
    READY   = 2'd2,
    ISSUED  = 2'd3
  } rs_state_e;

  localparam int RS_DEF_UNIT_ID_W = 1;
  localparam int RS_DEF_DEPTH     = 4;
  localparam int RS_DEF_DATA_W    = 32;
  localparam int RS_DEF_NUM_CDB   = 1;

  // Result is wide; callers cast down to their TAG_W.
  function automatic logic [31:0] rs_make_tag(input logic [31:0] unit_id,
                                              input logic [31:0] idx,
                                              input int          idx_w);
    return (unit_id << idx_w) | idx;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-ready picker.
//   ready      in  DEPTH         entry holds both operands and waits for issue
//   ages       in  DEPTH*AGE_W   packed per-entry ages (entry i at [i*AGE_W +: AGE_W])
//   sel_onehot out DEPTH         one-hot of the chosen entry
//   sel_idx    out AGE_W         binary index of the chosen entry
//   found      out 1             some entry was chosen
// Purely combinational.
module rs_oldest_select #(
  parameter  int DEPTH = 4,
  localparam int AGE_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*AGE_W-1:0] ages,
  output logic [DEPTH-1:0]       sel_onehot,
  output logic [AGE_W-1:0]       sel_idx,
  output logic                   found
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic wins;
    // An entry wins if no other ready entry is older. Ages are unique in
    // normal operation; the index tie-break only keeps the result one-hot.
    always_comb begin
      wins = ready[gi];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != gi && ready[j]) begin
          if (ages[j*AGE_W +: AGE_W] > ages[gi*AGE_W +: AGE_W])
            wins = 1'b0;
          else if (ages[j*AGE_W +: AGE_W] == ages[gi*AGE_W +: AGE_W] && j < gi)
            wins = 1'b0;
        end
      end
    end
    assign sel_onehot[gi] = wins;
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_onehot[i]) sel_idx = AGE_W'(i);
  end

  assign found = |sel_onehot;

endmodule

// File: rtl/rs_age_station.sv
// Reservation station for one functional unit.
// Holds up to DEPTH renamed instructions, snoops NUM_CDB broadcast buses for
// missing operands, issues the oldest READY entry over a valid/ready
// handshake, and frees an ISSUED entry when its own tag is broadcast.
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every entry at the next edge
//   disp_*            dispatch side: valid/ready, assigned tag, two operands
//   cdb_valid/tag/value  packed per-lane broadcasts
//   iss_*             issue side: valid/ready, tag and operands
//   count/full/empty  occupancy
module rs_age_station
  import rs_pkg::*;
#(
  parameter  int                   UNIT_ID_W = RS_DEF_UNIT_ID_W,
  parameter  logic [UNIT_ID_W-1:0] UNIT_ID   = '0,
  parameter  int                   DEPTH     = RS_DEF_DEPTH,
  parameter  int                   DATA_W    = RS_DEF_DATA_W,
  parameter  int                   NUM_CDB   = RS_DEF_NUM_CDB,
  localparam int                   IDX_W     = $clog2(DEPTH),
  localparam int                   TAG_W     = UNIT_ID_W + IDX_W,
  localparam int                   CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  output logic [TAG_W-1:0]          disp_tag,
  input  logic                      disp_src1_rdy,
  input  logic                      disp_src2_rdy,
  input  logic [TAG_W-1:0]          disp_src1_tag,
  input  logic [TAG_W-1:0]          disp_src2_tag,
  input  logic [DATA_W-1:0]         disp_src1_val,
  input  logic [DATA_W-1:0]         disp_src2_val,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [TAG_W-1:0]          iss_tag,
  output logic [DATA_W-1:0]         iss_a,
  output logic [DATA_W-1:0]         iss_b,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty
);

  // Entry storage
  rs_state_e         state_reg  [DEPTH];
  rs_state_e         state_next [DEPTH];
  logic [IDX_W-1:0]  age_reg    [DEPTH];
  logic [IDX_W-1:0]  age_next   [DEPTH];
  logic [DEPTH-1:0]  s1_rdy_reg, s1_rdy_next, s2_rdy_reg, s2_rdy_next;
  logic [TAG_W-1:0]  s1_tag_reg [DEPTH];
  logic [TAG_W-1:0]  s1_tag_next[DEPTH];
  logic [TAG_W-1:0]  s2_tag_reg [DEPTH];
  logic [TAG_W-1:0]  s2_tag_next[DEPTH];
  logic [DATA_W-1:0] s1_val_reg [DEPTH];
  logic [DATA_W-1:0] s1_val_next[DEPTH];
  logic [DATA_W-1:0] s2_val_reg [DEPTH];
  logic [DATA_W-1:0] s2_val_next[DEPTH];

  // Per-entry CDB matches
  logic [DEPTH-1:0]  s1_cdb_hit, s2_cdb_hit, own_free_hit, freeing;
  logic [DATA_W-1:0] s1_cdb_val [DEPTH];
  logic [DATA_W-1:0] s2_cdb_val [DEPTH];

  // Dispatch side
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              alloc;
  logic              d1_hit, d2_hit, d1_present, d2_present;
  logic [DATA_W-1:0] d1_val, d2_val, d1_data, d2_data;

  // Issue side
  logic [DEPTH-1:0]       ready_vec;
  logic [DEPTH*IDX_W-1:0] ages_flat;
  logic [DEPTH-1:0]       sel_onehot;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_found;
  logic                   iss_fire;

  // ---------------------------------------------------------------------
  // Per-entry snooping and age bookkeeping
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [TAG_W-1:0]  own_tag;
    logic              h1, h2, hf;
    logic [DATA_W-1:0] v1, v2;
    logic [IDX_W-1:0]  dec;

    assign own_tag = TAG_W'(rs_make_tag(32'(UNIT_ID), 32'(gi), IDX_W));

    // Scan lanes high to low so the lowest matching lane wins.
    always_comb begin
      h1 = 1'b0;
      h2 = 1'b0;
      hf = 1'b0;
      v1 = '0;
      v2 = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cdb_valid[k]) begin
          if (cdb_tag[k*TAG_W +: TAG_W] == s1_tag_reg[gi]) begin
            h1 = 1'b1;
            v1 = cdb_value[k*DATA_W +: DATA_W];
          end
          if (cdb_tag[k*TAG_W +: TAG_W] == s2_tag_reg[gi]) begin
            h2 = 1'b1;
            v2 = cdb_value[k*DATA_W +: DATA_W];
          end
          if (cdb_tag[k*TAG_W +: TAG_W] == own_tag) hf = 1'b1;
        end
      end
    end

    assign s1_cdb_hit[gi]   = h1;
    assign s2_cdb_hit[gi]   = h2;
    assign s1_cdb_val[gi]   = v1;
    assign s2_cdb_val[gi]   = v2;
    assign own_free_hit[gi] = hf;
    assign freeing[gi]      = (state_reg[gi] == ISSUED) && hf;

    // Ages stay a dense 0..count-1 set: entries older than a departing
    // entry step down, so the counter never wraps when slots are reused
    // out of order.
    always_comb begin
      dec = '0;
      for (int j = 0; j < DEPTH; j++)
        if (freeing[j] && age_reg[j] < age_reg[gi]) dec = dec + IDX_W'(1);
    end

    assign age_next[gi] = (state_reg[gi] == FREE || freeing[gi]) ? '0 :
                          age_reg[gi] + IDX_W'(alloc) - dec;

    assign ready_vec[gi]                  = (state_reg[gi] == READY);
    assign ages_flat[gi*IDX_W +: IDX_W]   = age_reg[gi];
  end

  // ---------------------------------------------------------------------
  // Dispatch: lowest free slot and same-cycle CDB bypass
  // ---------------------------------------------------------------------
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_reg[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    d1_hit = 1'b0;
    d2_hit = 1'b0;
    d1_val = '0;
    d2_val = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_src1_tag) begin
        d1_hit = 1'b1;
        d1_val = cdb_value[k*DATA_W +: DATA_W];
      end
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_src2_tag) begin
        d2_hit = 1'b1;
        d2_val = cdb_value[k*DATA_W +: DATA_W];
      end
    end
  end

  assign d1_present = disp_src1_rdy | d1_hit;
  assign d2_present = disp_src2_rdy | d2_hit;
  assign d1_data    = disp_src1_rdy ? disp_src1_val : d1_val;
  assign d2_data    = disp_src2_rdy ? disp_src2_val : d2_val;
  assign alloc      = disp_valid & free_found;

  // ---------------------------------------------------------------------
  // Oldest-ready selection
  // ---------------------------------------------------------------------
  rs_oldest_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .ready      (ready_vec),
    .ages       (ages_flat),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .found      (sel_found)
  );

  assign iss_fire = sel_found & iss_ready;

  // ---------------------------------------------------------------------
  // Entry next-state
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_next[i]  = state_reg[i];
      s1_rdy_next[i] = s1_rdy_reg[i];
      s2_rdy_next[i] = s2_rdy_reg[i];
      s1_tag_next[i] = s1_tag_reg[i];
      s2_tag_next[i] = s2_tag_reg[i];
      s1_val_next[i] = s1_val_reg[i];
      s2_val_next[i] = s2_val_reg[i];
      case (state_reg[i])
        FREE: begin
          if (alloc && free_idx == IDX_W'(i)) begin
            s1_rdy_next[i] = d1_present;
            s2_rdy_next[i] = d2_present;
            s1_tag_next[i] = disp_src1_tag;
            s2_tag_next[i] = disp_src2_tag;
            s1_val_next[i] = d1_data;
            s2_val_next[i] = d2_data;
            state_next[i]  = (d1_present && d2_present) ? READY : WAITING;
          end
        end
        WAITING: begin
          if (!s1_rdy_reg[i] && s1_cdb_hit[i]) begin
            s1_rdy_next[i] = 1'b1;
            s1_val_next[i] = s1_cdb_val[i];
          end
          if (!s2_rdy_reg[i] && s2_cdb_hit[i]) begin
            s2_rdy_next[i] = 1'b1;
            s2_val_next[i] = s2_cdb_val[i];
          end
          if (s1_rdy_next[i] && s2_rdy_next[i]) state_next[i] = READY;
        end
        READY: begin
          if (iss_fire && sel_onehot[i]) state_next[i] = ISSUED;
        end
        ISSUED: begin
          if (own_free_hit[i]) state_next[i] = FREE;
        end
        default: state_next[i] = FREE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || flush) begin
        state_reg[i] <= FREE;
        age_reg[i]   <= '0;
      end else begin
        state_reg[i] <= state_next[i];
        age_reg[i]   <= age_next[i];
      end
    end
  end

  // Payload is only meaningful while the entry is occupied, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_rdy_reg <= s1_rdy_next;
    s2_rdy_reg <= s2_rdy_next;
    for (int i = 0; i < DEPTH; i++) begin
      s1_tag_reg[i] <= s1_tag_next[i];
      s2_tag_reg[i] <= s2_tag_next[i];
      s1_val_reg[i] <= s1_val_next[i];
      s2_val_reg[i] <= s2_val_next[i];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      if (state_reg[i] != FREE) count = count + CNT_W'(1);
  end

  always_comb begin
    disp_ready = free_found;
    disp_tag   = TAG_W'(rs_make_tag(32'(UNIT_ID), 32'(free_idx), IDX_W));
    full       = ~free_found;
    empty      = (count == '0);
    iss_valid  = sel_found;
    iss_tag    = '0;
    iss_a      = '0;
    iss_b      = '0;
    if (sel_found) begin
      iss_tag = TAG_W'(rs_make_tag(32'(UNIT_ID), 32'(sel_idx), IDX_W));
      iss_a   = s1_val_reg[sel_idx];
      iss_b   = s2_val_reg[sel_idx];
    end
  end

endmodule

// File: tb/tb_rs_age_station.sv
// Directed bench for rs_age_station (UNIT_ID 0, DEPTH 4, two CDB lanes).
module tb_rs_age_station;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_CDB = 2;
  localparam int TAG_W   = 3;
  localparam int CNT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst, flush;
  logic                      disp_valid, disp_ready;
  logic [TAG_W-1:0]          disp_tag;
  logic                      disp_src1_rdy, disp_src2_rdy;
  logic [TAG_W-1:0]          disp_src1_tag, disp_src2_tag;
  logic [DATA_W-1:0]         disp_src1_val, disp_src2_val;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic                      iss_valid, iss_ready;
  logic [TAG_W-1:0]          iss_tag;
  logic [DATA_W-1:0]         iss_a, iss_b;
  logic [CNT_W-1:0]          count;
  logic                      full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rs_age_station #(
    .UNIT_ID_W (1),
    .UNIT_ID   (1'b0),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .NUM_CDB   (NUM_CDB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_tag      (disp_tag),
    .disp_src1_rdy (disp_src1_rdy),
    .disp_src2_rdy (disp_src2_rdy),
    .disp_src1_tag (disp_src1_tag),
    .disp_src2_tag (disp_src2_tag),
    .disp_src1_val (disp_src1_val),
    .disp_src2_val (disp_src2_val),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_tag       (iss_tag),
    .iss_a         (iss_a),
    .iss_b         (iss_b),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush         = 1'b0;
    disp_valid    = 1'b0;
    disp_src1_rdy = 1'b0;
    disp_src2_rdy = 1'b0;
    disp_src1_tag = '0;
    disp_src2_tag = '0;
    disp_src1_val = '0;
    disp_src2_val = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_value     = '0;
    iss_ready     = 1'b0;
  endtask

  task automatic set_cdb(input int lane, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    cdb_valid[lane]                = 1'b1;
    cdb_tag[lane*TAG_W +: TAG_W]   = t;
    cdb_value[lane*DATA_W +: DATA_W] = v;
  endtask

  task automatic disp(input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                      input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
    disp_valid    = 1'b1;
    disp_src1_rdy = r1;
    disp_src1_tag = t1;
    disp_src1_val = v1;
    disp_src2_rdy = r2;
    disp_src2_tag = t2;
    disp_src2_val = v2;
  endtask

  // Issue the presented entry, then broadcast its tag to free it.
  task automatic retire(input logic [TAG_W-1:0] t);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    set_cdb(0, t, 32'd0);
    tick();
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_disp_tag", disp_tag, 0);
    check("rst_iss_tag", iss_tag, 0);
    check("rst_iss_a", iss_a, 0);
    check("rst_iss_b", iss_b, 0);

    // Ready dispatch a=3 b=4
    disp(1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4);
    check("t1_disp_tag", disp_tag, 0);
    tick();
    clear_in();
    check("t1_iss_valid", iss_valid, 1);
    check("t1_iss_a", iss_a, 3);
    check("t1_iss_b", iss_b, 4);
    check("t1_iss_tag", iss_tag, 0);
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("t1_issued_valid", iss_valid, 0);
    check("t1_issued_count", count, 1);
    set_cdb(0, 3'd0, 32'd99);
    tick();
    clear_in();
    check("t1_freed_count", count, 0);
    check("t1_freed_empty", empty, 1);

    // Wait for tag 5, broadcast two cycles later
    disp(1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'd2);
    tick();
    clear_in();
    check("t2_wait_a", iss_valid, 0);
    tick();
    check("t2_wait_b", iss_valid, 0);
    set_cdb(0, 3'd5, 32'd9);
    tick();
    clear_in();
    check("t2_iss_valid", iss_valid, 1);
    check("t2_iss_a", iss_a, 9);
    check("t2_iss_b", iss_b, 2);
    retire(3'd0);
    check("t2_count", count, 0);

    // Dispatch-time bypass on lane 1
    disp(1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'd1);
    set_cdb(1, 3'd6, 32'd11);
    tick();
    clear_in();
    check("t3_iss_valid", iss_valid, 1);
    check("t3_iss_a", iss_a, 11);
    check("t3_iss_b", iss_b, 1);
    retire(3'd0);

    // Fill all entries, each waiting on tag 4+i
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b0, 3'(4 + i), 32'd0, 1'b1, 3'd0, 32'(100 + i));
      check($sformatf("t4_disp_tag%0d", i), disp_tag, i);
      tick();
      clear_in();
    end
    check("t4_full", full, 1);
    check("t4_disp_ready", disp_ready, 0);
    check("t4_count", count, 4);
    check("t4_iss_valid", iss_valid, 0);
    disp(1'b1, 3'd0, 32'd55, 1'b1, 3'd0, 32'd66);
    tick();
    clear_in();
    check("t4_drop_count", count, 4);
    check("t4_drop_valid", iss_valid, 0);
    set_cdb(0, 3'd6, 32'd22);
    tick();
    clear_in();
    check("t4_e2_tag", iss_tag, 2);
    check("t4_e2_a", iss_a, 22);
    check("t4_e2_b", iss_b, 102);
    set_cdb(0, 3'd4, 32'd20);
    tick();
    clear_in();
    check("t4_oldest_tag", iss_tag, 0);
    check("t4_oldest_a", iss_a, 20);
    check("t4_oldest_b", iss_b, 100);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("t4_next_tag", iss_tag, 2);

    // Issue entry 1 and free it by its own tag
    set_cdb(1, 3'd5, 32'd21);
    tick();
    clear_in();
    check("t5_e1_tag", iss_tag, 1);
    check("t5_e1_a", iss_a, 21);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("t5_after_issue_tag", iss_tag, 2);
    check("t5_after_issue_count", count, 4);
    set_cdb(0, 3'd1, 32'd0);
    disp(1'b1, 3'd0, 32'd55, 1'b1, 3'd0, 32'd66);
    check("t5_no_same_cycle_reuse", disp_ready, 0);
    tick();
    clear_in();
    check("t5_count", count, 3);
    check("t5_full", full, 0);
    check("t5_disp_ready", disp_ready, 1);
    check("t5_disp_tag", disp_tag, 1);
    disp(1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'd8);
    tick();
    clear_in();
    check("t5_refill_count", count, 4);
    check("t5_refill_tag", iss_tag, 2);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("t5_young_tag", iss_tag, 1);
    check("t5_young_a", iss_a, 7);

    // Flush with three occupied and a concurrent dispatch
    set_cdb(0, 3'd0, 32'd0);
    tick();
    clear_in();
    check("t6_pre_count", count, 3);
    flush = 1'b1;
    disp(1'b1, 3'd0, 32'd55, 1'b1, 3'd0, 32'd66);
    tick();
    clear_in();
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_iss_valid", iss_valid, 0);
    check("t6_disp_tag", disp_tag, 0);
    tick();
    check("t6_not_stored", count, 0);

    // Allocate and free in the same edge
    disp(1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd6);
    tick();
    clear_in();
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    set_cdb(0, 3'd0, 32'd0);
    disp(1'b1, 3'd0, 32'd13, 1'b1, 3'd0, 32'd14);
    check("t7_disp_tag", disp_tag, 1);
    tick();
    clear_in();
    check("t7_count", count, 1);
    check("t7_iss_tag", iss_tag, 1);
    check("t7_iss_a", iss_a, 13);

    // Reset with an entry present
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8_count", count, 0);
    check("t8_iss_valid", iss_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
